// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM status codes and memory arbiter states.
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  // Status reported by the RAM model every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter states: idle/arbitrating, serving fetch, serving data.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Debug grant encoding.
  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_I    = 2'd1;
  localparam logic [1:0] GRANT_D    = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and
// data load/store. Data wins by default; a streak counter forces a pending
// fetch through after MAX_DSTREAK consecutive data grants. The grant is held
// for the whole RAM transaction, and the winner sees a one-cycle !wait on the
// RAM's ACCESS cycle. Address/data are passed through live, not latched.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction fetch requester
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // data requester
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // debug
  output logic [1:0]        grant
);

  // Wide enough to hold 0..MAX_DSTREAK inclusive.
  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  ramstate_t     rs;
  logic          d_req;
  logic          fetch_forced;

  // Saturating increment so the streak never wraps back to zero.
  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    if (s >= STREAK_MAX) return STREAK_MAX;
    return s + SW'(1);
  endfunction

  assign rs           = ramstate_t'(ramstate);
  assign d_req        = dREN | dWEN;
  // A pending fetch that has already waited out a full data streak wins.
  assign fetch_forced = iREN && (dstreak_q == STREAK_MAX);

  // State and streak registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  // Next-state, streak update and output decode.
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    grant     = GRANT_NONE;

    unique case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d   = SERVE_D;
          // The streak only matters while a fetch is actually waiting.
          dstreak_d = iREN ? streak_inc(dstreak_q) : '0;
        end else if (iREN) begin
          state_d   = SERVE_I;
          dstreak_d = '0;
        end
      end

      SERVE_I: begin
        grant = GRANT_I;
        if (!iREN) begin
          // Fetch flushed by the pipeline: drop the access, no completion.
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iload   = ramload;
          if (rs == ACCESS) begin
            iwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end

      SERVE_D: begin
        grant = GRANT_D;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          // A simultaneous read and write request is a write.
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
            dload  = ramload;
          end
          // BUSY, ERROR and FREE all hold the access and keep driving.
          if (rs == ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized fetch/load/store traffic against a transaction-level model
// with a scoreboard of outstanding requests and a reference memory.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int W    = 32;
  localparam int MAXS = 4;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic [1:0]   ramstate;
  logic         iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;
  logic [1:0]   grant;

  always #5 CLK = ~CLK;

  mem_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .grant(grant)
  );

  typedef struct {
    logic [W-1:0] addr;
    logic         wr;
    logic [W-1:0] data;
  } req_t;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] ram_mem [16];
  logic [W-1:0] ref_mem [16];
  logic         ovr;
  logic [W-1:0] ovr_val;
  logic         mon_en;
  req_t         iq[$];
  req_t         dq[$];
  int           i_done_cnt = 0;
  int           d_done_cnt = 0;

  // RAM model: combinational read, optional forced read value.
  always_comb ramload = ovr ? ovr_val : ram_mem[ramaddr[5:2]];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Monitor: reference model of arbitration plus scoreboard, and RAM writes.
  initial begin : monitor
    int   m_owner;   // 0 none, 1 fetch, 2 data
    int   m_streak;
    logic exp_iw, exp_dw, exp_rr, exp_rw, addr_chk, done;
    logic [W-1:0] exp_addr;
    req_t e;
    m_owner  = 0;
    m_streak = 0;
    for (int k = 0; k < 16; k++) begin
      ram_mem[k] = $urandom;
      ref_mem[k] = ram_mem[k];
    end
    forever begin
      @(negedge CLK);
      if (mon_en && nRST) begin
        exp_iw = 1'b1; exp_dw = 1'b1; exp_rr = 1'b0; exp_rw = 1'b0;
        addr_chk = 1'b0; exp_addr = '0; done = 1'b0;
        chk("grant", {30'd0, grant}, W'(m_owner));
        if (m_owner == 1 && iREN) begin
          if (iq.size() == 0) begin
            chk("iq_nonempty", 32'd0, 32'd1);
          end else begin
            exp_rr = 1'b1; addr_chk = 1'b1; exp_addr = iq[0].addr;
            if (ramstate == ACCESS) begin
              e = iq.pop_front();
              exp_iw = 1'b0;
              chk("iload", iload, ref_mem[e.addr[5:2]]);
              i_done_cnt++;
              done = 1'b1;
            end
          end
        end else if (m_owner == 2 && (dREN || dWEN)) begin
          if (dq.size() == 0) begin
            chk("dq_nonempty", 32'd0, 32'd1);
          end else begin
            addr_chk = 1'b1; exp_addr = dq[0].addr;
            if (dq[0].wr) begin
              exp_rw = 1'b1;
              chk("ramstore", ramstore, dq[0].data);
            end else begin
              exp_rr = 1'b1;
            end
            if (ramstate == ACCESS) begin
              e = dq.pop_front();
              exp_dw = 1'b0;
              if (e.wr) ref_mem[e.addr[5:2]] = e.data;
              else      chk("dload", dload, ref_mem[e.addr[5:2]]);
              d_done_cnt++;
              done = 1'b1;
            end
          end
        end
        chk("iwait", W'(iwait), W'(exp_iw));
        chk("dwait", W'(dwait), W'(exp_dw));
        chk("ramREN", W'(ramREN), W'(exp_rr));
        chk("ramWEN", W'(ramWEN), W'(exp_rw));
        if (addr_chk) chk("ramaddr", ramaddr, exp_addr);
        // Model the next owner from the arbitration rules.
        if (m_owner == 0) begin
          if ((dREN || dWEN) && !(iREN && m_streak == MAXS)) begin
            m_owner  = 2;
            m_streak = iREN ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
          end else if (iREN) begin
            m_owner  = 1;
            m_streak = 0;
          end
        end else if (done || (m_owner == 1 && !iREN) || (m_owner == 2 && !(dREN || dWEN))) begin
          m_owner = 0;
        end
      end
      if (nRST && ramWEN && ramstate == ACCESS) begin
        ram_mem[ramaddr[5:2]] = ramstore;
        if (!mon_en) ref_mem[ramaddr[5:2]] = ramstore;
      end
    end
  end

  function automatic logic [1:0] pick_state();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return ACCESS;
    if (r < 16) return BUSY;
    if (r < 19) return ERROR;
    return FREE;
  endfunction

  initial begin : stimulus
    int   i_seen, d_seen, kind;
    logic i_act, d_act;
    req_t r;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE;
    ovr = 1'b0; ovr_val = '0; mon_en = 1'b0;

    // Reset values
    repeat (2) smp();
    chk("rst_iwait", W'(iwait), 32'd1);
    chk("rst_dwait", W'(dwait), 32'd1);
    chk("rst_ramREN", W'(ramREN), 32'd0);
    chk("rst_ramWEN", W'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_grant", W'(grant), 32'd0);
    cyc(); nRST = 1'b1;

    // Fetch completing on the first serve cycle
    cyc(); iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ovr = 1; ovr_val = 32'h8C220004;
    smp(); chk("f_idle_grant", W'(grant), 32'd0); chk("f_idle_iwait", W'(iwait), 32'd1);
    cyc(); smp();
    chk("f_grant", W'(grant), 32'd1);
    chk("f_ramREN", W'(ramREN), 32'd1);
    chk("f_ramaddr", ramaddr, 32'h40);
    chk("f_iwait", W'(iwait), 32'd0);
    chk("f_iload", iload, 32'h8C220004);
    chk("f_dwait", W'(dwait), 32'd1);
    cyc(); iREN = 0; ovr = 0;
    smp(); chk("f_back_idle", W'(grant), 32'd0);

    // Store held through three BUSY cycles
    cyc(); dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
    smp(); chk("w_idle_grant", W'(grant), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); ramstate = (k < 3) ? BUSY : ACCESS;
      smp();
      chk("w_ramWEN", W'(ramWEN), 32'd1);
      chk("w_ramREN", W'(ramREN), 32'd0);
      chk("w_ramstore", ramstore, 32'hDEADBEEF);
      chk("w_ramaddr", ramaddr, 32'h100);
      chk("w_dwait", W'(dwait), (k == 3) ? 32'd0 : 32'd1);
    end

    // Both requesters continuously: D,D,D,D,I with an idle bubble between
    cyc(); dWEN = 0; iREN = 1; dREN = 1; ramstate = ACCESS;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) cyc();
      smp();
      if (c % 2 == 0) chk("stream_bubble", W'(grant), 32'd0);
      else chk("stream_grant", W'(grant), ((((c - 1) / 2) % 5) == 4) ? 32'd1 : 32'd2);
    end

    // Fetch flushed mid-BUSY, then pending load granted
    cyc(); dREN = 0; iREN = 1; iaddr = 32'h44; ramstate = BUSY;
    smp(); chk("fl_idle", W'(grant), 32'd0);
    cyc(); smp(); chk("fl_grant", W'(grant), 32'd1); chk("fl_iwait_busy", W'(iwait), 32'd1);
    cyc(); iREN = 0; dREN = 1; daddr = 32'h8;
    smp();
    chk("fl_iwait_drop", W'(iwait), 32'd1);
    chk("fl_ramREN_drop", W'(ramREN), 32'd0);
    cyc(); smp(); chk("fl_idle_after", W'(grant), 32'd0); chk("fl_dwait_idle", W'(dwait), 32'd1);
    cyc(); ramstate = ACCESS;
    smp(); chk("fl_d_grant", W'(grant), 32'd2); chk("fl_dwait", W'(dwait), 32'd0);
    chk("fl_iwait_loser", W'(iwait), 32'd1);

    // Asynchronous reset mid-store
    cyc(); dREN = 0; dWEN = 1; daddr = 32'h100; dstore = 32'hCAFEF00D; ramstate = BUSY;
    smp(); chk("ar_idle", W'(grant), 32'd0);
    cyc(); smp(); chk("ar_grant", W'(grant), 32'd2); chk("ar_ramWEN", W'(ramWEN), 32'd1);
    #2; nRST = 1'b0; #1;
    chk("ar_ramWEN_rst", W'(ramWEN), 32'd0);
    chk("ar_dwait_rst", W'(dwait), 32'd1);
    chk("ar_grant_rst", W'(grant), 32'd0);
    chk("ar_ramstore_rst", ramstore, 32'd0);
    cyc(); nRST = 1'b1; ramstate = ACCESS;
    smp(); chk("ar_lat_idle", W'(grant), 32'd0); chk("ar_lat_dwait1", W'(dwait), 32'd1);
    cyc(); smp(); chk("ar_lat_grant", W'(grant), 32'd2); chk("ar_lat_dwait0", W'(dwait), 32'd0);

    // Load retried across two ERROR cycles
    cyc(); dWEN = 0; dREN = 1; daddr = 32'h200; ramstate = ERROR; ovr = 1; ovr_val = 32'h12345678;
    smp(); chk("er_idle", W'(grant), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); ramstate = (k < 2) ? ERROR : ACCESS;
      smp();
      chk("er_ramREN", W'(ramREN), 32'd1);
      chk("er_ramaddr", ramaddr, 32'h200);
      chk("er_dwait", W'(dwait), (k == 2) ? 32'd0 : 32'd1);
      if (k == 2) chk("er_dload", dload, 32'h12345678);
    end
    cyc(); dREN = 0; ovr = 0; mon_en = 1;

    // Randomized traffic against the model
    i_seen = 0; d_seen = 0; i_act = 0; d_act = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      ramstate = pick_state();
      if (i_done_cnt != i_seen) begin
        i_seen = i_done_cnt; i_act = 0; iREN = 0;
      end
      if (i_act && $urandom_range(0, 29) == 0) begin
        iREN = 0; i_act = 0; iq.delete(iq.size() - 1);
      end else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; iREN = 1;
        iaddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        r.addr = iaddr; r.wr = 1'b0; r.data = '0;
        iq.push_back(r);
      end
      if (d_done_cnt != d_seen) begin
        d_seen = d_done_cnt; d_act = 0; dREN = 0; dWEN = 0;
      end
      if (d_act && $urandom_range(0, 29) == 0) begin
        dREN = 0; dWEN = 0; d_act = 0; dq.delete(dq.size() - 1);
      end else if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1;
        kind = $urandom_range(0, 2);
        dREN = (kind != 1);
        dWEN = (kind != 0);
        daddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        dstore = $urandom;
        r.addr = daddr; r.wr = dWEN; r.data = dstore;
        dq.push_back(r);
      end
    end
    smp();
    mon_en = 0;
    chk("rand_i_progress", W'(i_done_cnt > 100), 32'd1);
    chk("rand_d_progress", W'(d_done_cnt > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single-ported RAM between the instruction-fetch requester and the data (load/store) requester of the pipelined datapath.
- Sits between the datapath/cache interface and the RAM model.
- Registers a grant, holds it for the whole RAM transaction, and returns a one-cycle completion to the winning requester.
- Data has priority; a streak counter stops instruction fetch from starving.

Parameters:
- WORD_W, 32, address/data width (matches word_t)
- MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending before the fetch is forced through (>=1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- iwait  out  1  high = fetch not complete this cycle
- iload  out  WORD_W  fetched instruction, valid when iREN && !iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  store data
- dwait  out  1  high = data access not complete this cycle
- dload  out  WORD_W  load data, valid when dREN && !dwait
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- grant  out  2  debug: 0 none, 1 instr, 2 data

Behaviour:
- Reset (async, nRST low), state -> IDLE, dstreak -> 0. Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, grant=0.
  - Reset mid-transaction abandons the access immediately; no completion pulse.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: no RAM enables; both waits high. On the clock edge, picks a winner:
  - (dREN|dWEN) && !(iREN && dstreak==MAX_DSTREAK) -> SERVE_D; dstreak increments if iREN, else clears.
  - else if iREN -> SERVE_I; dstreak clears.
  - else stay IDLE.
- SERVE_I:
  - Drives ramREN=1, ramaddr=iaddr (live input); iload=ramload.
  - ramstate==ACCESS: iwait=0 that cycle (combinational); next state IDLE.
  - iREN dropped (pipeline flush): next state IDLE, no RAM enable that cycle, iwait stays 1.
- SERVE_D:
  - Drives ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore, ramREN=0. Else ramREN=1; dload=ramload.
  - dREN and dWEN both high is treated as a write.
  - ramstate==ACCESS: dwait=0 for one cycle; next state IDLE.
  - Both data requests dropped: abort to IDLE, as in SERVE_I.
- The loser's wait stays 1 throughout. Only one of iwait/dwait is ever 0 in a cycle.
- BUSY or ERROR: hold the state and keep driving. ERROR is treated as retry; there is no timeout.
- Latency: minimum 2 cycles from request to !wait (1 arbitration cycle + 1 ACCESS cycle). There is always one IDLE bubble between transactions.
- grant = 1 in SERVE_I, 2 in SERVE_D, 0 in IDLE.
- dstreak saturates at MAX_DSTREAK and never wraps.
- Address and data are not latched. Requesters must hold iaddr/daddr/dstore stable until !wait.

Decomposition:
- cpu_types_pkg gets: ramstate_t enum (FREE, BUSY, ACCESS, ERROR), arb_state_t enum (IDLE, SERVE_I, SERVE_D), word_t reused.
- No sub-module. Next-state logic, output decode and the streak counter live in one module.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, RAM returns ACCESS on the 1st serve cycle with ramload=0x8C220004 -> cycle 1 grant=1, ramREN=1, ramaddr=0x40; iwait=0 and iload=0x8C220004 in that same cycle; IDLE next.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 held for 4 cycles; dwait=0 only in the ACCESS cycle; ramREN stays 0.
- iREN and dREN held high continuously, RAM always ACCESS, MAX_DSTREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I…; each grant is separated by an IDLE cycle.
- In SERVE_I with ramstate BUSY, iREN drops to 0 -> next cycle IDLE, no iwait=0 pulse; a pending dREN is granted on the following edge.
- nRST asserted in SERVE_D mid-BUSY -> outputs return to reset values asynchronously (ramWEN=0, dwait=1, grant=0); after release, a new request takes the 2-cycle minimum latency.
- ramstate=ERROR for 2 cycles then ACCESS during a data read of daddr=0x200 -> ramREN and ramaddr are held stable across the ERROR cycles; dload=ramload and dwait=0 on ACCESS.
